i2c_tx_fifo: RTL and testbench

Synchronous first-word-fall-through transmit FIFO between the APB register block and the I2C master engine. Each APB write to the transmit register pushes one byte. The I2C engine pops bytes as it shifts them onto SDA. Full/empty status feeds back into the APB block's `fifo_full_i`/`fifo_empty_i` inputs.

---
 rtl/i2c_pkg.sv | 23 ++
 rtl/i2c_fifo_mem.sv | 25 ++
 rtl/i2c_tx_fifo.sv | 126 ++++++++++++
 tb/tb_i2c_tx_fifo.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared I2C constants: FIFO geometry, APB register map and FIFO op encoding.
// Used by both the TX and RX FIFOs and the APB register block.
package i2c_pkg;

    localparam int I2C_DATA_WIDTH      = 8;
    localparam int I2C_FIFO_DEPTH_LOG2 = 4;

    localparam logic [7:0] I2C_REG_TRANSMIT = 8'h00;
    localparam logic [7:0] I2C_REG_RECEIVE  = 8'h01;
    localparam logic [7:0] I2C_REG_CONTROL  = 8'h02;
    localparam logic [7:0] I2C_REG_STATUS   = 8'h03;
    localparam logic [7:0] I2C_REG_COMMAND  = 8'h04;
    localparam logic [7:0] I2C_REG_PRESCALE = 8'h05;

    // Encoded as {pop, push} so the accepted strobes can be cast directly.
    typedef enum logic [1:0] {
        FIFO_OP_IDLE = 2'b00,
        FIFO_OP_PUSH = 2'b01,
        FIFO_OP_POP  = 2'b10,
        FIFO_OP_BOTH = 2'b11
    } fifo_op_e;

endpackage

// File: rtl/i2c_fifo_mem.sv
// Register-array storage for the I2C FIFOs: one synchronous write port and
// one asynchronous read port. Contents are deliberately not reset.
module i2c_fifo_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/i2c_tx_fifo.sv
// First-word-fall-through transmit FIFO between the APB block and I2C engine.
// Optional sticky overflow/underflow flags under I2C_FIFO_ERR_FLAGS_EN.
module i2c_tx_fifo
    import i2c_pkg::*;
#(
    parameter int DATA_WIDTH = I2C_DATA_WIDTH,
    parameter int DEPTH_LOG2 = I2C_FIFO_DEPTH_LOG2
) (
    input  logic                  pclk_i,
    input  logic                  preset_i,
    input  logic                  clr_i,
    input  logic                  wr_en_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  rd_en_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [DEPTH_LOG2:0]   count_o
`ifdef I2C_FIFO_ERR_FLAGS_EN
    ,
    output logic                  overflow_o,
    output logic                  underflow_o
`endif
);

    localparam int PW = DEPTH_LOG2 + 1;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          full, empty;
    logic          push_ok, pop_ok, mem_we;
    fifo_op_e      op;

    // Extra MSB on each pointer distinguishes full from empty when the
    // low bits coincide.
    always_comb begin
        empty = (wr_ptr_q == rd_ptr_q);
        full  = (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]) &&
                (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]);
    end

    // A push into a full FIFO is still accepted when a pop frees the head
    // slot in the same cycle; a pop of an empty FIFO never is.
    always_comb begin
        pop_ok  = rd_en_i && !empty;
        push_ok = wr_en_i && (!full || pop_ok);
        op      = fifo_op_e'({pop_ok, push_ok});
        mem_we  = push_ok && !clr_i;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            unique case (op)
                FIFO_OP_PUSH: wr_ptr_d = wr_ptr_q + PW'(1);
                FIFO_OP_POP:  rd_ptr_d = rd_ptr_q + PW'(1);
                FIFO_OP_BOTH: begin
                    wr_ptr_d = wr_ptr_q + PW'(1);
                    rd_ptr_d = rd_ptr_q + PW'(1);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge pclk_i or posedge preset_i) begin
        if (preset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    i2c_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (DEPTH_LOG2)
    ) u_mem (
        .clk_i   (pclk_i),
        .we_i    (mem_we),
        .waddr_i (wr_ptr_q[DEPTH_LOG2-1:0]),
        .wdata_i (wr_data_i),
        .raddr_i (rd_ptr_q[DEPTH_LOG2-1:0]),
        .rdata_o (rd_data_o)
    );

    assign full_o  = full;
    assign empty_o = empty;
    assign count_o = wr_ptr_q - rd_ptr_q;

`ifdef I2C_FIFO_ERR_FLAGS_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    always_comb begin
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (clr_i) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (wr_en_i && !push_ok) overflow_d  = 1'b1;
            if (rd_en_i && !pop_ok)  underflow_d = 1'b1;
        end
    end

    always_ff @(posedge pclk_i or posedge preset_i) begin
        if (preset_i) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow_o  = overflow_q;
    assign underflow_o = underflow_q;
`endif

endmodule

// File: tb/tb_i2c_tx_fifo.sv
// Self-checking bench for i2c_tx_fifo: directed steps plus randomized traffic
// compared against a queue-based reference model.
module tb_i2c_tx_fifo;

    localparam int DEPTH = 16;

    logic       pclk_i = 1'b0;
    logic       preset_i;
    logic       clr_i;
    logic       wr_en_i;
    logic [7:0] wr_data_i;
    logic       rd_en_i;
    logic [7:0] rd_data_o;
    logic       full_o;
    logic       empty_o;
    logic [4:0] count_o;
`ifdef I2C_FIFO_ERR_FLAGS_EN
    logic       overflow_o;
    logic       underflow_o;
`endif

    int checks   = 0;
    int failures = 0;

    logic [7:0] mq[$];
    bit         m_ovf;
    bit         m_unf;

    always #5 pclk_i = ~pclk_i;

    i2c_tx_fifo dut (
        .pclk_i    (pclk_i),
        .preset_i  (preset_i),
        .clr_i     (clr_i),
        .wr_en_i   (wr_en_i),
        .wr_data_i (wr_data_i),
        .rd_en_i   (rd_en_i),
        .rd_data_o (rd_data_o),
        .full_o    (full_o),
        .empty_o   (empty_o),
        .count_o   (count_o)
`ifdef I2C_FIFO_ERR_FLAGS_EN
        ,
        .overflow_o  (overflow_o),
        .underflow_o (underflow_o)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, ".count"}, 32'(count_o), 32'(mq.size()));
        check({tag, ".empty"}, 32'(empty_o), 32'(mq.size() == 0));
        check({tag, ".full"},  32'(full_o),  32'(mq.size() == DEPTH));
        if (mq.size() > 0) check({tag, ".data"}, 32'(rd_data_o), 32'(mq[0]));
`ifdef I2C_FIFO_ERR_FLAGS_EN
        check({tag, ".ovf"}, 32'(overflow_o),  32'(m_ovf));
        check({tag, ".unf"}, 32'(underflow_o), 32'(m_unf));
`endif
    endtask

    // Model applies the acceptance rules to the occupancy seen before the edge.
    task automatic step(input bit w, input logic [7:0] d, input bit r, input bit c, input string tag);
        bit was_full, was_empty;
        wr_en_i   = w;
        wr_data_i = d;
        rd_en_i   = r;
        clr_i     = c;
        @(posedge pclk_i);
        was_full  = (mq.size() == DEPTH);
        was_empty = (mq.size() == 0);
        if (c) begin
            mq.delete();
            m_ovf = 0;
            m_unf = 0;
        end else begin
            if (w && was_full && !r) m_ovf = 1;
            if (r && was_empty) m_unf = 1;
            if (r && !was_empty) void'(mq.pop_front());
            if (w && (!was_full || r)) mq.push_back(d);
        end
        #1;
        wr_en_i = 0;
        rd_en_i = 0;
        clr_i   = 0;
        check_state(tag);
    endtask

    initial begin
        preset_i  = 1;
        clr_i     = 0;
        wr_en_i   = 0;
        wr_data_i = 0;
        rd_en_i   = 0;
        m_ovf     = 0;
        m_unf     = 0;
        #23;
        check_state("reset");
        preset_i = 0;
        step(0, 8'h00, 0, 0, "idle");

        step(1, 8'h11, 0, 0, "push11");
        check("push11.head", 32'(rd_data_o), 32'h11);
        step(1, 8'h22, 0, 0, "push22");
        step(1, 8'h33, 0, 0, "push33");
        step(0, 8'h00, 1, 0, "pop1");
        check("pop1.head", 32'(rd_data_o), 32'h22);
        step(0, 8'h00, 1, 0, "pop2");
        check("pop2.head", 32'(rd_data_o), 32'h33);
        step(0, 8'h00, 1, 0, "pop3");
        check("pop3.empty", 32'(empty_o), 32'h1);

        for (int i = 0; i < DEPTH; i++) step(1, 8'(i), 0, 0, "fill");
        check("fill.count", 32'(count_o), 32'd16);
        step(1, 8'hAA, 0, 0, "push_full");
        check("push_full.full", 32'(full_o), 32'h1);
        for (int i = 0; i < DEPTH; i++) begin
            check("drain.data", 32'(rd_data_o), 32'(i));
            step(0, 8'h00, 1, 0, "drain");
        end

        for (int i = 0; i < DEPTH; i++) step(1, 8'(8'h40 + i), 0, 0, "fill2");
        step(1, 8'h55, 1, 0, "full_both");
        check("full_both.count", 32'(count_o), 32'd16);
        for (int i = 0; i < DEPTH - 1; i++) step(0, 8'h00, 1, 0, "drain2");
        check("drain2.last", 32'(rd_data_o), 32'h55);
        step(0, 8'h00, 1, 0, "drain2_end");

        step(1, 8'h77, 1, 0, "empty_both");
        check("empty_both.count", 32'(count_o), 32'd1);
        check("empty_both.data", 32'(rd_data_o), 32'h77);
        step(0, 8'h00, 1, 0, "empty_both_pop");

        for (int i = 0; i < 20; i++) step(1, 8'(8'hC0 + i), (i % 3) == 2, 0, "wrap");
        step(1, 8'hEE, 0, 1, "clr_wr");
        check("clr_wr.count", 32'(count_o), 32'd0);

        for (int i = 0; i < 6; i++) step(1, 8'(8'h90 + i), 0, 0, "burst");
        @(posedge pclk_i);
        #3;
        wr_en_i  = 1;
        preset_i = 1;
        #1;
        mq.delete();
        m_ovf = 0;
        m_unf = 0;
        check_state("async_rst");
        #10;
        wr_en_i  = 0;
        preset_i = 0;
        step(0, 8'h00, 0, 0, "post_rst");

        for (int i = 0; i < 600; i++) begin
            int pw;
            pw = ((i / 100) % 2 == 0) ? 70 : 30;
            step($urandom_range(0, 99) < pw, 8'($urandom),
                 $urandom_range(0, 99) < (100 - pw),
                 $urandom_range(0, 63) == 0, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
